// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the decryption core:
//   - FSM state enum for aes_decrypt_core
//   - GF(2^8) arithmetic (xtime, multiply, inverse)
//   - forward / inverse S-box, computed from the field inverse and the
//     affine transform rather than stored as tables
//   - Rcon lookup, SubWord / RotWord, forward and inverse key-schedule steps
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } aesState_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gfMul(p, p);
         r = gfMul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] i;
      i = gfInv(b);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
               ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] b);
      logic [7:0] y;
      y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gfInv(y);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rotWord(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // rk_i from rk_{i-1}, rc = Rcon[i]
   function automatic logic [127:0] keyStepFwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ subWord(rotWord(k[31:0])) ^ {rc, 24'h000000};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0]  ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // rk_i from rk_{i+1}, rc = Rcon[i+1]; undoes keyStepFwd word by word,
   // the last word first because word 0 depends on the recovered word 3.
   function automatic logic [127:0] keyStepInv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ subWord(rotWord(w3)) ^ {rc, 24'h000000};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// InvMixColumns is bypassed when lastRound is high (final round, rk0).
// Ports:
//   stateIn   [127:0] in   round input state (byte 0 in [127:120])
//   roundKey  [127:0] in   round key to add
//   lastRound        in   1 = skip InvMixColumns
//   stateOut  [127:0] out  round result
// ---------------------------------------------------------------------------
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] stateIn,
   input  logic [127:0] roundKey,
   input  logic         lastRound,
   output logic [127:0] stateOut
);

   logic [127:0] shifted;
   logic [127:0] added;
   logic [127:0] mixed;

   function automatic logic [31:0] invMixCol(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09),
              gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d),
              gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b),
              gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e)};
   endfunction

   always_comb begin
      shifted = '0;
      added   = '0;
      mixed   = '0;
      // Byte k sits at row k%4, column k/4; row r rotates right by r.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127 - 8*(4*c + r) -: 8] = stateIn[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
         end
      end
      for (int k = 0; k < 16; k++) begin
         added[127 - 8*k -: 8] = invSbox(shifted[127 - 8*k -: 8]) ^ roundKey[127 - 8*k -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         mixed[127 - 32*c -: 32] = invMixCol(added[127 - 32*c -: 32]);
      end
      stateOut = lastRound ? added : mixed;
   end

endmodule

// File: rtl/aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// aes_decrypt_core
// Iterative AES-128 decryption, one inverse round per clock.
// A request (ciphertext + key) is accepted in IDLE. On a key-cache miss the
// round-10 key is derived by ten forward key steps (KEYEXP); on a hit the
// cached round-10 key is used directly. ROUND then walks the key schedule
// backwards while applying ten inverse rounds; DONE holds the plaintext
// until the downstream handshake.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        request handshake
//   in_ciphertext, in_key      128-bit block and cipher key
//   out_valid / out_ready      result handshake
//   out_plaintext              128-bit decrypted block
//   busy                       high in KEYEXP or ROUND
// ---------------------------------------------------------------------------
module aes_decrypt_core
   import aes_pkg::*;
#(
   parameter bit KEY_CACHE_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_ciphertext,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_plaintext,
   output logic         busy
);

   aesState_e    state, stateNext;
   logic [3:0]   cnt;
   logic [127:0] stateReg;
   logic [127:0] keyReg;
   logic [127:0] ctReg;
   logic [127:0] cipherKey;
   logic [127:0] outPt;
   logic [127:0] cacheKey;
   logic [127:0] cacheRk;
   logic         cacheVld;

   logic         cacheHit;
   logic [127:0] keyNext;
   logic [127:0] rkCur;
   logic [127:0] roundOut;

   assign cacheHit = KEY_CACHE_EN && cacheVld && (in_key == cacheKey);
   assign keyNext  = keyStepFwd(keyReg, rcon(cnt));
   assign rkCur    = keyStepInv(keyReg, rcon(cnt + 4'd1));

   aes_inv_round uInvRound (
      .stateIn   (stateReg),
      .roundKey  (rkCur),
      .lastRound (cnt == 4'd0),
      .stateOut  (roundOut)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // FSM next state
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (in_valid)          stateNext = cacheHit ? ROUND : KEYEXP;
         KEYEXP:  if (cnt == 4'd10)      stateNext = ROUND;
         ROUND:   if (cnt == 4'd0)       stateNext = DONE;
         DONE:    if (out_ready)         stateNext = IDLE;
         default:                        stateNext = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready      = (state == IDLE);
      out_valid     = (state == DONE);
      busy          = (state == KEYEXP) || (state == ROUND);
      out_plaintext = outPt;
   end

   // Datapath, key schedule and cache
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         stateReg  <= '0;
         keyReg    <= '0;
         ctReg     <= '0;
         cipherKey <= '0;
         outPt     <= '0;
         cacheKey  <= '0;
         cacheRk   <= '0;
         cacheVld  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (cacheHit) begin
                     stateReg <= in_ciphertext ^ cacheRk;
                     keyReg   <= cacheRk;
                     cnt      <= 4'd9;
                  end else begin
                     ctReg     <= in_ciphertext;
                     cipherKey <= in_key;
                     keyReg    <= in_key;
                     cnt       <= 4'd1;
                  end
               end
            end
            KEYEXP: begin
               keyReg <= keyNext;
               if (cnt == 4'd10) begin
                  // keyNext is rk10: initial AddRoundKey and cache fill
                  stateReg <= ctReg ^ keyNext;
                  cnt      <= 4'd9;
                  if (KEY_CACHE_EN) begin
                     cacheKey <= cipherKey;
                     cacheRk  <= keyNext;
                     cacheVld <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ROUND: begin
               stateReg <= roundOut;
               keyReg   <= rkCur;
               if (cnt == 4'd0) outPt <= roundOut;
               else             cnt   <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_core
// Directed FIPS-197 vectors through aes_decrypt_core: miss and hit latency,
// key change, input sampling, backpressure and reset in the middle of ROUND.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_core;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_ciphertext;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_plaintext;
   logic         busy;

   int nChecks = 0;
   int nPass   = 0;

   aes_decrypt_core #(.KEY_CACHE_EN(1'b1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_ciphertext (in_ciphertext),
      .in_key        (in_key),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_plaintext (out_plaintext),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Issue one request and wait (bounded) for out_valid. Inputs are
   // scrambled right after the accept edge.
   task automatic doReq(input logic [127:0] ct, input logic [127:0] key, input bit holdValid,
                        output int lat, output int busyCnt, output int rdyBad);
      in_ciphertext = ct;
      in_key        = key;
      in_valid      = 1'b1;
      checkVal("in_ready before accept", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_ciphertext = ~ct;
      in_key        = ~key;
      if (!holdValid) in_valid = 1'b0;
      lat = 0; busyCnt = 0; rdyBad = 0;
      while (!out_valid && lat < 100) begin
         if (busy) busyCnt++;
         if (in_ready) rdyBad++;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
   endtask

   task automatic finishReq(input string tag, input logic [127:0] expPt);
      checkVal({tag, " plaintext"}, out_plaintext, expPt);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkVal({tag, " out_valid drop"}, 128'(out_valid), 128'd0);
      checkVal({tag, " in_ready back"}, 128'(in_ready), 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, bc, rb, good;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ciphertext = '0; in_key = '0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("reset in_ready", 128'(in_ready), 128'd1);
      checkVal("reset out_valid", 128'(out_valid), 128'd0);
      checkVal("reset busy", 128'(busy), 128'd0);
      checkVal("reset out_plaintext", out_plaintext, 128'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // C.1, cold cache
      doReq(CT1, K1, 1'b0, lat, bc, rb);
      checkVal("c1 miss latency", 128'(lat), 128'd20);
      checkVal("c1 miss busy cycles", 128'(bc), 128'd20);
      checkVal("c1 in_ready while busy", 128'(rb), 128'd0);
      finishReq("c1 miss", PT1);

      // C.1 again, cache hit
      doReq(CT1, K1, 1'b0, lat, bc, rb);
      checkVal("c1 hit latency", 128'(lat), 128'd10);
      checkVal("c1 hit busy cycles", 128'(bc), 128'd10);
      finishReq("c1 hit", PT1);

      // App. B, different key
      doReq(CT2, K2, 1'b0, lat, bc, rb);
      checkVal("appB latency", 128'(lat), 128'd20);
      finishReq("appB", PT2);

      // back to C.1 key with in_valid held high throughout
      doReq(CT1, K1, 1'b1, lat, bc, rb);
      checkVal("keychg latency", 128'(lat), 128'd20);
      checkVal("keychg in_ready while busy", 128'(rb), 128'd0);
      finishReq("keychg", PT1);

      // backpressure on a hit
      doReq(CT1, K1, 1'b0, lat, bc, rb);
      checkVal("bp latency", 128'(lat), 128'd10);
      in_valid = 1'b1;
      in_ciphertext = CT2;
      in_key = K2;
      good = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid && !in_ready && !busy && out_plaintext === PT1) good++;
      end
      checkVal("bp stable cycles", 128'(good), 128'd15);
      in_valid = 1'b0;
      finishReq("bp release", PT1);

      // reset in the middle of ROUND (hit path, counter at 5)
      in_ciphertext = CT1; in_key = K1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkVal("busy before reset", 128'(busy), 128'd1);
      rst_n = 1'b0;
      #1;
      checkVal("midreset out_valid", 128'(out_valid), 128'd0);
      checkVal("midreset in_ready", 128'(in_ready), 128'd1);
      checkVal("midreset busy", 128'(busy), 128'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      doReq(CT1, K1, 1'b0, lat, bc, rb);
      checkVal("post-reset latency", 128'(lat), 128'd20);
      finishReq("post-reset", PT1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
- Iterative AES-128 decryption engine (FIPS-197 inverse cipher); the receive-side counterpart of the encryption datapath.
- Accepts one 128-bit ciphertext plus cipher key over a valid/ready handshake.
- Runs one inverse round per clock and returns the plaintext over a valid/ready handshake.
- Derives the last round key internally by forward key expansion, optionally cached, then walks the key schedule backwards during decryption.

Parameters:
- KEY_CACHE_EN, 1, when 1 retain the last expanded round-10 key and skip re-expansion if the next request uses the same cipher key.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ciphertext/key request valid.
- in_ready  output  1  core can accept a request.
- in_ciphertext  input  128  ciphertext block; bits [127:120] = byte 0, column-major per FIPS-197.
- in_key  input  128  AES-128 cipher key, same byte order.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- out_plaintext  output  128  decrypted block.
- busy  output  1  high in KEYEXP or ROUND.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; in_ready=1; out_valid=0; out_plaintext=0; busy=0.
  - Cache-valid flag cleared; all datapath registers zeroed.
  - Reset mid-operation abandons the block; no output is produced.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- in_ready = (state==IDLE). Requests are never accepted in other states.
- Accept edge (in_valid && in_ready), branching on key-cache hit:
  - Cache hit means KEY_CACHE_EN=1, cache valid, and in_key == cached key. Then: state_reg = in_ciphertext ^ cached rk10; key_reg = cached rk10; round counter = 9; go to ROUND.
  - Otherwise: latch ciphertext and key; key_reg = in_key; counter = 1; go to KEYEXP.
- KEYEXP:
  - Each edge computes key_reg = forward key step (RotWord, SubWord, Rcon[counter]); counter++.
  - On the 10th step: key_reg = rk10; state_reg = ciphertext ^ rk10; cache updated (key, rk10, valid=1); counter = 9; go to ROUND.
- ROUND:
  - Counter r = 9..1: state_reg = InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_r).
  - r = 0: state_reg = InvSubBytes(InvShiftRows(state_reg)) ^ rk0; out_plaintext loaded; go to DONE.
  - rk_r is produced combinationally from key_reg (rk_{r+1}) by the inverse key step: w[i] = w[i+4] ^ w[i+3] for the upper three words, then the SubWord/RotWord/Rcon term for word 0. key_reg advances to rk_r on each edge.
- DONE:
  - out_valid=1; out_plaintext stable until out_valid && out_ready.
  - On the handshake edge: out_valid=0, go to IDLE.
  - A back-to-back request is accepted no earlier than the following cycle.
- Latency from accept edge to out_valid high:
  - Cache miss: 20 edges (10 KEYEXP + 10 ROUND).
  - Cache hit: 10 edges.
- Backpressure: out_ready held low keeps DONE indefinitely; the cache and output do not change.
- in_ciphertext and in_key are sampled only at the accept edge; later changes are ignored.
- KEY_CACHE_EN=0: the cache logic is removed and every request takes the miss path.

Decomposition:
- Package aes_pkg: 256-entry forward and inverse S-box constants (or functions); Rcon[1..10]; GF(2^8) xtime/multiply functions; forward and inverse key-step functions; FSM state enum.
- Sub-module aes_inv_round: combinational InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns, selected by a last_round input.
- The FSM, counter, key schedule registers and cache live in aes_decrypt_core.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff; out_valid 20 edges after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- Cache hit: repeat the C.1 request immediately after it completes → same pt after 10 edges; busy high for exactly 10 cycles.
- Key change: App. B then C.1 → second request takes 20 edges with the correct pt; in_ready=0 throughout KEYEXP/ROUND despite in_valid held high.
- Backpressure: out_ready=0 for 15 cycles after out_valid → output stable, in_ready=0; release → out_valid drops next edge, in_ready=1.
- Reset mid-ROUND (rst_n low at round 5) → out_valid=0 and in_ready=1 immediately; the next C.1 request takes the 20-edge miss path (cache cleared) and returns the correct pt.
